// File: rtl/alu_issue_sched_if.sv
// Handshake bundle between the ALU reservation stations, the ALU, the CDB arbiter and
// the ALU issue scheduler.
interface alu_issue_sched_if #(
    parameter int unsigned ROB_DEPTH = 8,
    parameter int unsigned NUM_RS    = 4
);
    localparam int unsigned TW = $clog2(ROB_DEPTH);

    logic                       flush;
    logic [NUM_RS-1:0]          rs_req;
    logic [NUM_RS-1:0][31:0]    rs_instr_i;
    logic [NUM_RS-1:0][31:0]    rs_data_A_i;
    logic [NUM_RS-1:0][31:0]    rs_data_B_i;
    logic [NUM_RS-1:0][TW-1:0]  rs_tag_i;
    logic [NUM_RS-1:0]          rs_grant;
    logic [31:0]                rs_instr;
    logic [31:0]                rs_data_A;
    logic [31:0]                rs_data_B;
    logic                       rs_alu_en;
    logic [TW-1:0]              rs_dest_tag;
    logic                       alu_resp;
    logic [31:0]                alu_result;
    logic [TW-1:0]              alu_tag_CDB;
    logic                       cdb_valid;
    logic [31:0]                cdb_data;
    logic [TW-1:0]              cdb_tag;
    logic                       cdb_gnt;
    logic                       illegal_op;

    modport master (
        output flush, rs_req, rs_instr_i, rs_data_A_i, rs_data_B_i, rs_tag_i,
               alu_resp, alu_result, alu_tag_CDB, cdb_gnt,
        input  rs_grant, rs_instr, rs_data_A, rs_data_B, rs_alu_en, rs_dest_tag,
               cdb_valid, cdb_data, cdb_tag, illegal_op
    );

    modport slave (
        input  flush, rs_req, rs_instr_i, rs_data_A_i, rs_data_B_i, rs_tag_i,
               alu_resp, alu_result, alu_tag_CDB, cdb_gnt,
        output rs_grant, rs_instr, rs_data_A, rs_data_B, rs_alu_en, rs_dest_tag,
               cdb_valid, cdb_data, cdb_tag, illegal_op
    );
endinterface

// File: rtl/alu_issue_sched.sv
// Round-robin issue of ready ALU reservation-station entries into an execute register,
// with a 2-entry writeback queue feeding the CDB through a valid/grant handshake.
module alu_issue_sched #(
    parameter int unsigned ROB_DEPTH = 8,
    parameter int unsigned NUM_RS    = 4
) (
    input logic         clk,
    input logic         rst,
    alu_issue_sched_if.slave bus
);
    localparam int unsigned TW = $clog2(ROB_DEPTH);
    localparam int unsigned RW = $clog2(NUM_RS);

    logic              e_valid_q;
    logic [31:0]       e_instr_q;
    logic [31:0]       e_a_q;
    logic [31:0]       e_b_q;
    logic [TW-1:0]     e_tag_q;
    logic [31:0]       q_data_q [2];
    logic [TW-1:0]     q_tag_q  [2];
    logic              q_head_q;
    logic              q_tail_q;
    logic [1:0]        q_count_q;
    logic [RW-1:0]     rr_q;

    logic              pop;
    logic              push;
    logic              e_drain;
    logic              can_issue;
    logic              gnt_found;
    logic              issue;
    logic [RW-1:0]     gnt_idx;
    logic [RW-1:0]     scan_idx;

    always_comb begin
        pop       = (q_count_q != 2'd0) & bus.cdb_gnt;
        e_drain   = e_valid_q & (~bus.alu_resp | (q_count_q != 2'd2) | pop);
        can_issue = ~bus.flush & (~e_valid_q | e_drain);
        push      = e_drain & bus.alu_resp & ~bus.flush;
        gnt_found = 1'b0;
        gnt_idx   = rr_q;
        scan_idx  = rr_q;
        // Scan starts at rr and wraps naturally because NUM_RS is a power of two
        for (int unsigned k = 0; k < NUM_RS; k++) begin
            scan_idx = rr_q + RW'(k);
            if (!gnt_found && bus.rs_req[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
        // Grant is combinational, so it must be masked while reset is held
        issue = can_issue & gnt_found & ~rst;
    end

    assign bus.rs_grant    = issue ? (NUM_RS'(1) << gnt_idx) : '0;
    assign bus.rs_alu_en   = e_valid_q;
    assign bus.rs_instr    = e_instr_q;
    assign bus.rs_data_A   = e_a_q;
    assign bus.rs_data_B   = e_b_q;
    assign bus.rs_dest_tag = e_tag_q;
    assign bus.cdb_valid   = (q_count_q != 2'd0);
    assign bus.cdb_data    = q_data_q[q_head_q];
    assign bus.cdb_tag     = q_tag_q[q_head_q];
    assign bus.illegal_op  = e_drain & ~bus.alu_resp & ~bus.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_valid_q   <= 1'b0;
            e_instr_q   <= '0;
            e_a_q       <= '0;
            e_b_q       <= '0;
            e_tag_q     <= '0;
            q_data_q[0] <= '0;
            q_data_q[1] <= '0;
            q_tag_q[0]  <= '0;
            q_tag_q[1]  <= '0;
            q_head_q    <= 1'b0;
            q_tail_q    <= 1'b0;
            q_count_q   <= 2'd0;
            rr_q        <= '0;
        end else if (bus.flush) begin
            e_valid_q <= 1'b0;
            q_head_q  <= 1'b0;
            q_tail_q  <= 1'b0;
            q_count_q <= 2'd0;
        end else begin
            if (issue) begin
                e_valid_q <= 1'b1;
                e_instr_q <= bus.rs_instr_i[gnt_idx];
                e_a_q     <= bus.rs_data_A_i[gnt_idx];
                e_b_q     <= bus.rs_data_B_i[gnt_idx];
                e_tag_q   <= bus.rs_tag_i[gnt_idx];
                rr_q      <= gnt_idx + RW'(1);
            end else if (e_drain) begin
                e_valid_q <= 1'b0;
            end
            if (push) begin
                q_data_q[q_tail_q] <= bus.alu_result;
                q_tag_q[q_tail_q]  <= bus.alu_tag_CDB;
                q_tail_q           <= ~q_tail_q;
            end
            if (pop) begin
                q_head_q <= ~q_head_q;
            end
            q_count_q <= q_count_q + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_alu_issue_sched.sv
// Self-checking bench for alu_issue_sched: directed scenario tasks plus a scoreboard that
// predicts every CDB result at issue time and checks it when the head is accepted.
module tb_alu_issue_sched;
    localparam int unsigned ROB_DEPTH = 8;
    localparam int unsigned NUM_RS    = 4;
    localparam int unsigned TW        = 3;

    typedef struct packed {
        logic [31:0]   data;
        logic [TW-1:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_issue_sched_if #(.ROB_DEPTH(ROB_DEPTH), .NUM_RS(NUM_RS)) bus ();

    alu_issue_sched #(.ROB_DEPTH(ROB_DEPTH), .NUM_RS(NUM_RS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Combinational ALU model: opcode 0 is not recognised, everything else adds
    assign bus.alu_resp    = bus.rs_alu_en && (bus.rs_instr[6:0] != 7'd0);
    assign bus.alu_result  = bus.rs_data_A + bus.rs_data_B;
    assign bus.alu_tag_CDB = bus.rs_dest_tag;

    int              vectors     = 0;
    int              miscompares = 0;
    exp_t            sb_q[$];
    exp_t            mon_exp;
    exp_t            mon_got;
    logic [NUM_RS-1:0] last_grant = '0;
    bit              refill_en   = 1'b0;
    int              op_limit    = 1000;
    int              ops_made    = 0;
    logic [TW-1:0]   next_tag    = '0;

    // Scoreboard: predict on grant, compare on accepted head
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            last_grant = '0;
        end else begin
            last_grant = bus.rs_grant;
            if (bus.cdb_valid && bus.cdb_gnt) begin
                vectors++;
                mon_got = {bus.cdb_data, bus.cdb_tag};
                if (sb_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_pop: got data %h tag %0d, required no result", bus.cdb_data,
                             bus.cdb_tag);
                end else begin
                    mon_exp = sb_q.pop_front();
                    if (mon_got !== mon_exp) begin
                        miscompares++;
                        $display("FAIL sb_pop: got data %h tag %0d, required data %h tag %0d",
                                 bus.cdb_data, bus.cdb_tag, mon_exp.data, mon_exp.tag);
                    end
                end
            end
            if (bus.flush) sb_q.delete();
            for (int i = 0; i < NUM_RS; i++) begin
                if (bus.rs_grant[i] && bus.rs_instr_i[i][6:0] != 7'd0) begin
                    mon_exp.data = bus.rs_data_A_i[i] + bus.rs_data_B_i[i];
                    mon_exp.tag  = bus.rs_tag_i[i];
                    sb_q.push_back(mon_exp);
                end
            end
        end
    end

    task automatic new_op(input int i, input logic [6:0] opc);
        bus.rs_instr_i[i]  = {25'($urandom), opc};
        bus.rs_data_A_i[i] = $urandom;
        bus.rs_data_B_i[i] = $urandom;
        bus.rs_tag_i[i]    = next_tag;
        next_tag++;
        ops_made++;
        bus.rs_req[i] = 1'b1;
    endtask

    // Advance one edge; granted entries free themselves or reload a fresh op
    task automatic clk_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_RS; i++) begin
            if (last_grant[i]) begin
                if (refill_en && ops_made < op_limit) new_op(i, 7'h13);
                else bus.rs_req[i] = 1'b0;
            end
        end
        last_grant = '0;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.flush   = 1'b0;
        bus.rs_req  = '0;
        bus.cdb_gnt = 1'b0;
        refill_en   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        last_grant = '0;
        ops_made   = 0;
        op_limit   = 1000;
    endtask

    task automatic drain();
        int n = 0;
        bus.cdb_gnt = 1'b1;
        refill_en   = 1'b0;
        while ((bus.cdb_valid || bus.rs_alu_en || bus.rs_req != '0) && n < 50) begin
            clk_step();
            n++;
        end
        vectors++;
        if (n >= 50 || sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d cycles, %0d pending results, required <50 and 0", n,
                     sb_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < NUM_RS; i++) new_op(i, 7'h13);
        bus.cdb_gnt = 1'b1;
        #2;
        vectors++;
        if (bus.rs_grant !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_grant: got %b required 0000", bus.rs_grant);
        end
        vectors++;
        if ({bus.cdb_valid, bus.rs_alu_en, bus.illegal_op} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b required 000",
                     {bus.cdb_valid, bus.rs_alu_en, bus.illegal_op});
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        bus.cdb_gnt        = 1'b1;
        bus.rs_instr_i[0]  = 32'h0072_8293;
        bus.rs_data_A_i[0] = 32'd5;
        bus.rs_data_B_i[0] = 32'd7;
        bus.rs_tag_i[0]    = 3'd3;
        bus.rs_req         = 4'b0001;
        @(negedge clk);
        vectors++;
        if (bus.rs_grant !== 4'b0001) begin
            miscompares++;
            $display("FAIL single_grant: got %b required 0001", bus.rs_grant);
        end
        clk_step();
        @(negedge clk);
        vectors++;
        if (bus.rs_alu_en !== 1'b1 || bus.rs_dest_tag !== 3'd3) begin
            miscompares++;
            $display("FAIL single_exec: got en %b tag %0d required en 1 tag 3", bus.rs_alu_en,
                     bus.rs_dest_tag);
        end
        clk_step();
        @(negedge clk);
        vectors++;
        if (bus.cdb_valid !== 1'b1 || bus.cdb_data !== 32'd12 || bus.cdb_tag !== 3'd3) begin
            miscompares++;
            $display("FAIL single_cdb: got v %b data %0d tag %0d required v 1 data 12 tag 3",
                     bus.cdb_valid, bus.cdb_data, bus.cdb_tag);
        end
        clk_step();
        @(negedge clk);
        vectors++;
        if (bus.cdb_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_done: got cdb_valid %b required 0", bus.cdb_valid);
        end
        drain();
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.cdb_gnt = 1'b1;
        refill_en   = 1'b1;
        for (int i = 0; i < NUM_RS; i++) new_op(i, 7'h13);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++;
            if (bus.rs_grant !== 4'(1 << (k % 4))) begin
                miscompares++;
                $display("FAIL rr_grant%0d: got %b required %b", k, bus.rs_grant,
                         4'(1 << (k % 4)));
            end
            clk_step();
        end
        do_reset();
        bus.cdb_gnt = 1'b1;
        new_op(1, 7'h13);
        new_op(3, 7'h13);
        @(negedge clk);
        vectors++;
        if (bus.rs_grant !== 4'b0010) begin
            miscompares++;
            $display("FAIL rr_sparse0: got %b required 0010", bus.rs_grant);
        end
        clk_step();
        @(negedge clk);
        vectors++;
        if (bus.rs_grant !== 4'b1000) begin
            miscompares++;
            $display("FAIL rr_sparse1: got %b required 1000", bus.rs_grant);
        end
        clk_step();
        drain();
    endtask

    task automatic test_backpressure();
        int grants = 0;
        do_reset();
        refill_en = 1'b1;
        for (int i = 0; i < NUM_RS; i++) new_op(i, 7'h13);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.rs_grant != '0) grants++;
            if (k >= 3) begin
                vectors++;
                if (bus.rs_grant !== 4'b0000 || bus.cdb_valid !== 1'b1 ||
                    bus.cdb_data !== sb_q[0].data || bus.cdb_tag !== sb_q[0].tag) begin
                    miscompares++;
                    $display("FAIL bp_stall%0d: got gnt %b v %b data %h, required 0000 1 %h", k,
                             bus.rs_grant, bus.cdb_valid, bus.cdb_data, sb_q[0].data);
                end
            end
            clk_step();
        end
        vectors++;
        if (grants != 3) begin
            miscompares++;
            $display("FAIL bp_grants: got %0d required 3", grants);
        end
        bus.cdb_gnt = 1'b1;
        @(negedge clk);
        vectors++;
        if ($onehot(bus.rs_grant) !== 1'b1 || bus.cdb_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_resume: got gnt %b v %b required one-hot and 1", bus.rs_grant,
                     bus.cdb_valid);
        end
        clk_step();
        drain();
    endtask

    task automatic test_push_pop();
        logic [NUM_RS-1:0] exp_gnt [3];
        exp_gnt[0] = 4'b1000;
        exp_gnt[1] = 4'b0001;
        exp_gnt[2] = 4'b0010;
        do_reset();
        next_tag  = '0;
        op_limit  = 6;
        refill_en = 1'b1;
        for (int i = 0; i < NUM_RS; i++) new_op(i, 7'h13);
        for (int k = 0; k < 4; k++) clk_step();
        bus.cdb_gnt = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            vectors++;
            if (bus.cdb_valid !== 1'b1 || bus.cdb_tag !== TW'(k)) begin
                miscompares++;
                $display("FAIL pp_order%0d: got v %b tag %0d required v 1 tag %0d", k,
                         bus.cdb_valid, bus.cdb_tag, k);
            end
            if (k < 3) begin
                vectors++;
                if (bus.rs_grant !== exp_gnt[k]) begin
                    miscompares++;
                    $display("FAIL pp_grant%0d: got %b required %b", k, bus.rs_grant,
                             exp_gnt[k]);
                end
            end
            clk_step();
        end
        @(negedge clk);
        vectors++;
        if (bus.cdb_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL pp_empty: got cdb_valid %b required 0", bus.cdb_valid);
        end
        drain();
    endtask

    task automatic test_illegal();
        do_reset();
        bus.cdb_gnt        = 1'b1;
        bus.rs_instr_i[0]  = 32'h0000_0000;
        bus.rs_data_A_i[0] = 32'd9;
        bus.rs_data_B_i[0] = 32'd9;
        bus.rs_tag_i[0]    = 3'd1;
        bus.rs_instr_i[1]  = 32'h0020_8093;
        bus.rs_data_A_i[1] = 32'd1;
        bus.rs_data_B_i[1] = 32'd2;
        bus.rs_tag_i[1]    = 3'd2;
        bus.rs_req         = 4'b0011;
        @(negedge clk);
        vectors++;
        if (bus.rs_grant !== 4'b0001 || bus.illegal_op !== 1'b0) begin
            miscompares++;
            $display("FAIL ill_issue: got gnt %b ill %b required 0001 0", bus.rs_grant,
                     bus.illegal_op);
        end
        clk_step();
        @(negedge clk);
        vectors++;
        if (bus.illegal_op !== 1'b1 || bus.rs_grant !== 4'b0010 || bus.cdb_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL ill_pulse: got ill %b gnt %b v %b required 1 0010 0", bus.illegal_op,
                     bus.rs_grant, bus.cdb_valid);
        end
        clk_step();
        @(negedge clk);
        vectors++;
        if (bus.illegal_op !== 1'b0 || bus.cdb_valid !== 1'b0 || bus.rs_dest_tag !== 3'd2) begin
            miscompares++;
            $display("FAIL ill_after: got ill %b v %b tag %0d required 0 0 2", bus.illegal_op,
                     bus.cdb_valid, bus.rs_dest_tag);
        end
        clk_step();
        @(negedge clk);
        vectors++;
        if (bus.cdb_valid !== 1'b1 || bus.cdb_tag !== 3'd2 || bus.cdb_data !== 32'd3) begin
            miscompares++;
            $display("FAIL ill_next: got v %b tag %0d data %0d required 1 2 3", bus.cdb_valid,
                     bus.cdb_tag, bus.cdb_data);
        end
        clk_step();
        drain();
    endtask

    task automatic test_flush();
        do_reset();
        refill_en = 1'b1;
        for (int i = 0; i < NUM_RS; i++) new_op(i, 7'h13);
        for (int k = 0; k < 4; k++) clk_step();
        bus.flush   = 1'b1;
        bus.cdb_gnt = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.rs_grant !== 4'b0000 || bus.cdb_valid !== 1'b1 || bus.rs_alu_en !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_cycle: got gnt %b v %b en %b required 0000 1 1", bus.rs_grant,
                     bus.cdb_valid, bus.rs_alu_en);
        end
        clk_step();
        bus.flush = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.cdb_valid !== 1'b0 || bus.rs_alu_en !== 1'b0 || bus.rs_grant !== 4'b1000) begin
            miscompares++;
            $display("FAIL flush_after: got v %b en %b gnt %b required 0 0 1000", bus.cdb_valid,
                     bus.rs_alu_en, bus.rs_grant);
        end
        clk_step();
        drain();
    endtask

    task automatic test_async_reset();
        bus.cdb_gnt = 1'b1;
        refill_en   = 1'b1;
        op_limit    = ops_made + 1000;
        for (int i = 0; i < NUM_RS; i++) new_op(i, 7'h13);
        for (int k = 0; k < 5; k++) clk_step();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({bus.rs_grant, bus.rs_alu_en, bus.cdb_valid, bus.illegal_op} !== '0) begin
            miscompares++;
            $display("FAIL arst_ctrl: got gnt %b en %b v %b ill %b required all 0",
                     bus.rs_grant, bus.rs_alu_en, bus.cdb_valid, bus.illegal_op);
        end
        vectors++;
        if ({bus.cdb_data, bus.cdb_tag, bus.rs_dest_tag} !== '0) begin
            miscompares++;
            $display("FAIL arst_cdb: got data %h tag %0d dtag %0d required 0", bus.cdb_data,
                     bus.cdb_tag, bus.rs_dest_tag);
        end
        vectors++;
        if ({bus.rs_instr, bus.rs_data_A, bus.rs_data_B} !== '0) begin
            miscompares++;
            $display("FAIL arst_exec: got %h %h %h required 0", bus.rs_instr, bus.rs_data_A,
                     bus.rs_data_B);
        end
        refill_en  = 1'b0;
        bus.rs_req = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_RS; i++) new_op(i, 7'h13);
        rst        = 1'b0;
        last_grant = '0;
        @(negedge clk);
        vectors++;
        if (bus.rs_grant !== 4'b0001) begin
            miscompares++;
            $display("FAIL arst_first: got %b required 0001", bus.rs_grant);
        end
        clk_step();
        drain();
    endtask

    initial begin
        bus.flush   = 1'b0;
        bus.cdb_gnt = 1'b0;
        bus.rs_req  = '0;
        bus.rs_instr_i  = '0;
        bus.rs_data_A_i = '0;
        bus.rs_data_B_i = '0;
        bus.rs_tag_i    = '0;
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_push_pop();
        test_illegal();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
